// File: rtl/a_skew_feeder.sv
// A-operand feeder: pops one word per bank, serialises its bytes and skews lane i by i cycles
// so the systolic array sees a diagonal wavefront.

module a_skew_lane #(
  parameter int WORD_BYTES = 32,
  parameter int DEPTH      = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          adv_i,
  input  logic                          load_i,
  input  logic [WORD_BYTES*8-1:0]       word_i,
  input  logic [$clog2(WORD_BYTES)-1:0] sel_i,
  input  logic                          vld_i,
  output logic [7:0]                    byte_o,
  output logic                          vld_o
);
  logic [WORD_BYTES-1:0][7:0] cur_q;
  logic [DEPTH-1:0][7:0]      data_q;
  logic [DEPTH-1:0]           vld_q;

  // The byte is taken from cur_q before a same-cycle reload, which is what
  // makes word boundaries seamless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q  <= '0;
      data_q <= '0;
      vld_q  <= '0;
    end else if (adv_i) begin
      if (load_i) cur_q <= word_i;
      data_q[0] <= vld_i ? cur_q[sel_i] : 8'h00;
      vld_q[0]  <= vld_i;
      for (int j = 1; j < DEPTH; j++) begin
        data_q[j] <= data_q[j-1];
        vld_q[j]  <= vld_q[j-1];
      end
    end
  end

  assign byte_o = data_q[DEPTH-1];
  assign vld_o  = vld_q[DEPTH-1];
endmodule

module a_skew_feeder #(
  parameter int LANE_NUM   = 16,
  parameter int WORD_W     = 264,
  parameter int WORD_BYTES = 32,
  parameter int NUM_WORDS  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         stall,
  output logic                         rd_en,
  input  logic [LANE_NUM*WORD_W-1:0]   rd_data,
  output logic [LANE_NUM*8-1:0]        a_out,
  output logic [LANE_NUM-1:0]          a_valid,
  output logic                         busy,
  output logic                         done
);
  localparam int BW = $clog2(WORD_BYTES);
  localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int DW = $clog2(LANE_NUM + 1);
  localparam int DB = WORD_BYTES * 8;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM, S_DRAIN} state_e;

  state_e          state_q;
  logic [BW-1:0]   byte_cnt_q;
  logic [WW-1:0]   word_cnt_q;
  logic [DW-1:0]   drain_cnt_q;
  logic            busy_q, done_q;
  logic            last_byte, last_word, last_drain, stream_vld, adv;

  assign last_byte  = (byte_cnt_q  == BW'(WORD_BYTES - 1));
  assign last_word  = (word_cnt_q  == WW'(NUM_WORDS - 1));
  assign last_drain = (drain_cnt_q == DW'(LANE_NUM - 1));
  assign stream_vld = (state_q == S_STREAM);
  assign adv        = !stall;

  assign rd_en = adv && ((state_q == S_FETCH) ||
                         (state_q == S_STREAM && last_byte && !last_word));

  // The extra drain step past the last flush is the cycle done is raised.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (adv) begin
        unique case (state_q)
          S_IDLE: if (start && !done_q) begin
            state_q    <= S_FETCH;
            word_cnt_q <= '0;
            busy_q     <= 1'b1;
          end
          S_FETCH: begin
            state_q    <= S_STREAM;
            byte_cnt_q <= '0;
          end
          S_STREAM: begin
            if (!last_byte) begin
              byte_cnt_q <= byte_cnt_q + BW'(1);
            end else if (!last_word) begin
              byte_cnt_q <= '0;
              word_cnt_q <= word_cnt_q + WW'(1);
            end else begin
              state_q     <= S_DRAIN;
              drain_cnt_q <= '0;
            end
          end
          S_DRAIN: begin
            if (last_drain) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              drain_cnt_q <= drain_cnt_q + DW'(1);
            end
          end
        endcase
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  for (genvar i = 0; i < LANE_NUM; i++) begin : g_lane
    logic unused_tag;
    assign unused_tag = ^rd_data[i*WORD_W + DB +: WORD_W - DB];

    a_skew_lane #(.WORD_BYTES(WORD_BYTES), .DEPTH(i + 1)) u_lane (
      .clk    (clk),
      .rst    (rst_n),
      .adv_i  (adv),
      .load_i (rd_en),
      .word_i (rd_data[i*WORD_W +: DB]),
      .sel_i  (byte_cnt_q),
      .vld_i  (stream_vld),
      .byte_o (a_out[i*8 +: 8]),
      .vld_o  (a_valid[i])
    );
  end
endmodule

// File: tb/tb_a_skew_feeder.sv
// Scoreboard bench: each run pushes the expected per-lane byte stream, rd_en and done
// cycles; a negedge monitor pops and compares whatever the DUT presents.

module tb_a_skew_feeder;
  localparam int L  = 16;
  localparam int WW = 264;
  localparam int NB = 32;
  localparam int NW = 8;

  logic             clk = 1'b0;
  logic             rst_n, start, stall, rd_en, busy, done;
  logic [L*WW-1:0]  rd_data;
  logic [L*8-1:0]   a_out;
  logic [L-1:0]     a_valid;

  always #5 clk = ~clk;

  a_skew_feeder #(.LANE_NUM(L), .WORD_W(WW), .WORD_BYTES(NB), .NUM_WORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .rd_en(rd_en),
    .rd_data(rd_data), .a_out(a_out), .a_valid(a_valid), .busy(busy), .done(done)
  );

  // Bank model: byte(i,w,k) = i + 32w + k; tag byte carries junk.
  logic [2:0] rptr;
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) rptr <= '0;
    else if (rd_en) rptr <= rptr + 3'd1;
  end
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < L; i++) begin
      for (int k = 0; k < NB; k++)
        rd_data[i*WW + k*8 +: 8] = 8'(i + 32*int'(rptr) + k);
      rd_data[i*WW + 256 +: 8] = 8'hA5 ^ 8'(i);
    end
  end

  int cyc = 0;
  bit adv_last = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    adv_last <= !stall && !rst_n;
  end

  typedef struct { int t; logic [7:0] b; } exp_t;
  exp_t lq[L][$];
  int   rq[$];
  int   dq[$];
  int   checks = 0;
  int   passes = 0;

  task automatic note(input bit ok, input string msg);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s", msg);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      if (adv_last) begin
        for (int i = 0; i < L; i++) begin
          if (a_valid[i]) begin
            if (lq[i].size() == 0) begin
              note(1'b0, $sformatf("lane%0d_extra: got %02h at cycle %0d, required no byte",
                                   i, a_out[i*8 +: 8], cyc));
            end else begin
              exp_t e;
              e = lq[i].pop_front();
              note(e.t == cyc && e.b == a_out[i*8 +: 8],
                   $sformatf("lane%0d_byte: got %02h at cycle %0d, required %02h at cycle %0d",
                             i, a_out[i*8 +: 8], cyc, e.b, e.t));
            end
          end
        end
      end
      if (rd_en) begin
        if (rq.size() == 0) note(1'b0, $sformatf("rd_en_extra: got pulse at cycle %0d, required none", cyc));
        else begin
          int t;
          t = rq.pop_front();
          note(t == cyc, $sformatf("rd_en_cycle: got %0d required %0d", cyc, t));
        end
      end
      if (done) begin
        if (dq.size() == 0) note(1'b0, $sformatf("done_extra: got pulse at cycle %0d, required none", cyc));
        else begin
          int t;
          t = dq.pop_front();
          note(t == cyc, $sformatf("done_cycle: got %0d required %0d", cyc, t));
        end
      end
    end
  end

  // Events produced at edge >= s are pushed out by the n stalled edges.
  task automatic push_run(input int e0, input int s, input int n, input int cut);
    exp_t e;
    int   t;
    for (int i = 0; i < L; i++)
      for (int w = 0; w < NW; w++)
        for (int k = 0; k < NB; k++) begin
          t = e0 + 2 + w*NB + k + i;
          if (t >= s) t += n;
          if (t <= cut) begin
            e.t = t;
            e.b = 8'(i + w*NB + k);
            lq[i].push_back(e);
          end
        end
    for (int w = 0; w < NW; w++) begin
      t = e0 + w*NB;
      if (t + 1 >= s) t += n;
      if (t <= cut) rq.push_back(t);
    end
    t = e0 + 273;
    if (t >= s) t += n;
    if (t <= cut) dq.push_back(t);
  endtask

  task automatic run(input int s_rel, input int n, input int xs, input int cut_rel,
                     input int end_rel, output int e0);
    int s;
    start = 1'b1;
    @(posedge clk); #1;
    e0    = cyc;
    start = 1'b0;
    s     = (n > 0) ? e0 + s_rel : e0 + 100000;
    push_run(e0, s, n, e0 + cut_rel);
    while (cyc < e0 + end_rel) begin
      @(posedge clk); #1;
      stall = (n > 0) && (cyc + 1 >= s) && (cyc + 1 < s + n);
      start = (xs > 0) && (cyc == e0 + xs - 1);
    end
    stall = 1'b0;
  endtask

  task automatic settle(input string nm);
    int left;
    repeat (3) @(posedge clk);
    #1;
    left = rq.size() + dq.size();
    for (int i = 0; i < L; i++) left += lq[i].size();
    note(left == 0, $sformatf("%s_outstanding: got %0d, required 0", nm, left));
    note(busy == 1'b0, $sformatf("%s_busy_end: got %0d required 0", nm, busy));
    rq.delete();
    dq.delete();
    for (int i = 0; i < L; i++) lq[i].delete();
  endtask

  initial begin
    int e0;
    rst_n = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    #1;
    note(a_valid == '0, $sformatf("reset_a_valid: got %h required 0", a_valid));
    note(a_out == '0,   $sformatf("reset_a_out: got nonzero %0d required 0", a_out != '0));
    note(busy == 1'b0,  $sformatf("reset_busy: got %0d required 0", busy));
    note(done == 1'b0,  $sformatf("reset_done: got %0d required 0", done));
    note(rd_en == 1'b0, $sformatf("reset_rd_en: got %0d required 0", rd_en));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;

    run(0, 0, 0, 9999, 274, e0);   settle("plain");
    run(80, 3, 0, 9999, 277, e0);  settle("stall_mid_word");
    run(33, 2, 0, 9999, 276, e0);  settle("stall_on_rd_en");

    // Extra start mid-run, then start held across the done cycle.
    run(0, 0, 50, 9999, 273, e0);
    start = 1'b1;
    @(posedge clk); #1;
    note(busy == 1'b0, $sformatf("start_with_done: got busy %0d required 0", busy));
    run(0, 0, 0, 9999, 274, e0);   settle("rerun");

    // Async reset at E0+100 aborts; nothing after edge E0+99 may appear.
    run(0, 0, 0, 99, 100, e0);
    rst_n = 1'b1;
    #1;
    note(a_valid == '0, $sformatf("abort_a_valid: got %h required 0", a_valid));
    note(busy == 1'b0,  $sformatf("abort_busy: got %0d required 0", busy));
    note(rd_en == 1'b0, $sformatf("abort_rd_en: got %0d required 0", rd_en));
    note(done == 1'b0,  $sformatf("abort_done: got %0d required 0", done));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    settle("abort");
    run(0, 0, 0, 9999, 274, e0);   settle("after_abort");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
